// File: rtl/cart_sram_mapper.sv
// -----------------------------------------------------------------------------
// cart_sram_mapper
//
// MSX cartridge bank mapper with battery-backed SRAM paging. Sits between the
// slot decoder and the cart storage. 0x4000-0xBFFF is split into
// 2**(15-WINDOW_BITS) switchable windows. Each window's bank register selects
// either a ROM bank or a 4 KB SRAM page. A dirty tracker raises save_req after
// SAVE_IDLE quiet cycles following an SRAM write, and holds it until save_ack.
//
// Optional build macro: MAPPER_REG_READBACK_EN
//   defined     - a read of the first byte of a window's register area
//                 returns that window's bank register (registered, one cycle
//                 latency) and suppresses mem_oe/sram_oe for that access.
//   not defined - d_oe/d_to_cpu are tied low; register-area reads map normally.
//
// Ports:
//   clk, reset_n    clock, asynchronous active-low reset
//   addr            CPU address
//   d_from_cpu      CPU write data
//   wr, rd          CPU write / read strobes
//   cs              slot select for 0x4000-0xBFFF
//   mem_addr        ROM byte address        mem_oe     ROM read enable
//   sram_addr       SRAM byte address       sram_oe    SRAM selected
//   sram_we         SRAM write enable
//   d_to_cpu, d_oe  register readback data / drive enable
//   sram_dirty      SRAM modified since the last completed save
//   save_req        save request            save_ack   save complete pulse
// -----------------------------------------------------------------------------
module cart_sram_mapper #(
  parameter int         WINDOW_BITS    = 13,
  parameter int         BANK_W         = 6,
  parameter int         SRAM_SEL_BIT   = 4,
  parameter int         SRAM_PAGE_BITS = 1,
  parameter logic [3:0] SRAM_WR_MASK   = 4'b1000,
  parameter bit         FIXED_WIN0     = 1'b1,
  parameter int         SAVE_IDLE      = 50000
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [15:0]                 addr,
  input  logic [7:0]                  d_from_cpu,
  input  logic                        wr,
  input  logic                        rd,
  input  logic                        cs,
  output logic [24:0]                 mem_addr,
  output logic                        mem_oe,
  output logic [SRAM_PAGE_BITS+11:0]  sram_addr,
  output logic                        sram_oe,
  output logic                        sram_we,
  output logic [7:0]                  d_to_cpu,
  output logic                        d_oe,
  output logic                        sram_dirty,
  output logic                        save_req,
  input  logic                        save_ack
);

  localparam int WIDX_W   = 15 - WINDOW_BITS;          // window index width
  localparam int NUM_WIN  = 1 << WIDX_W;
  localparam int SEL_W    = 16 - WINDOW_BITS;          // width of addr[15:WINDOW_BITS]
  localparam logic [SEL_W-1:0] WIN_BASE = SEL_W'(16'h4000 >> WINDOW_BITS);
  localparam int PAGE_LSB = SRAM_SEL_BIT + 1;
  localparam int PAGE_MSB = SRAM_SEL_BIT + SRAM_PAGE_BITS;
  localparam logic [BANK_W-1:0] LOW_MASK = BANK_W'((1 << SRAM_SEL_BIT) - 1);
  localparam int TIMER_W  = $clog2(SAVE_IDLE) + 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SAVE_IDLE - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX  = {TIMER_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIRTY = 2'd1,
    ST_REQ   = 2'd2
  } save_state_t;

  logic [BANK_W-1:0]  bank_r [NUM_WIN];
  logic [SEL_W-1:0]   win_raw_s;
  logic [WIDX_W-1:0]  w_s;
  logic               in_range_s;
  logic               access_s;
  logic               reg_area_s;
  logic [BANK_W-1:0]  cur_bank_s;
  logic               sel_s;
  logic [BANK_W-1:0]  rom_bank_s;
  logic               reg_wr_s;
  logic               win_locked_s;
  logic               rb_hit_s;
  logic               sram_we_s;

  save_state_t        state_r;
  logic [TIMER_W-1:0] timer_r;
  logic               pend_r;
  logic               dirty_r;
  logic               save_req_r;

  // Address decode: window index, register area and current bank.
  assign win_raw_s  = addr[15:WINDOW_BITS] - WIN_BASE;
  assign w_s        = win_raw_s[WIDX_W-1:0];
  assign in_range_s = (addr[15:14] == 2'b01) || (addr[15:14] == 2'b10);
  assign access_s   = cs & in_range_s;
  assign reg_area_s = (addr[WINDOW_BITS-1:12] == '0);
  assign cur_bank_s = bank_r[w_s];
  assign sel_s      = cur_bank_s[SRAM_SEL_BIT];

  // ROM bank number: bank register with the SRAM select and page bits squeezed
  // out, so the bits above them close the gap.
  assign rom_bank_s = (cur_bank_s & LOW_MASK) |
                      BANK_W'((cur_bank_s >> (PAGE_MSB + 1)) << SRAM_SEL_BIT);

  assign reg_wr_s     = access_s & wr & reg_area_s;
  assign win_locked_s = FIXED_WIN0 && (w_s == '0);

  // Combinational mapping onto ROM/SRAM from the current bank registers.
  always_comb begin
    mem_oe    = 1'b0;
    sram_oe   = 1'b0;
    sram_we_s = 1'b0;
    mem_addr  = 25'd0;
    sram_addr = '0;
    if (access_s && !rb_hit_s) begin
      mem_oe    = ~sel_s;
      sram_oe   = sel_s;
      sram_we_s = wr & sel_s & SRAM_WR_MASK[w_s] & ~reg_area_s;
      mem_addr  = 25'({rom_bank_s, addr[WINDOW_BITS-1:0]});
      // The 4 KB SRAM page repeats across the whole window.
      sram_addr = {cur_bank_s[PAGE_MSB:PAGE_LSB], addr[11:0]};
    end else begin
      mem_oe    = 1'b0;
      sram_oe   = 1'b0;
    end
  end

  assign sram_we = sram_we_s;

  // Bank registers: window i resets to bank i; window 0 may be locked.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_WIN; i++) begin
        bank_r[i] <= BANK_W'(i);
      end
    end else if (reg_wr_s && !win_locked_s) begin
      bank_r[w_s] <= d_from_cpu[BANK_W-1:0];
    end
  end

  // Save handshake: dirty tracking, idle timer and request/acknowledge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      timer_r    <= '0;
      pend_r     <= 1'b0;
      dirty_r    <= 1'b0;
      save_req_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (sram_we_s) begin
            state_r <= ST_DIRTY;
            dirty_r <= 1'b1;
            timer_r <= '0;
          end
        end
        ST_DIRTY: begin
          if (sram_we_s) begin
            timer_r <= '0;
          end else if (timer_r == TIMER_LAST) begin
            state_r    <= ST_REQ;
            save_req_r <= 1'b1;
          end else if (timer_r != TIMER_MAX) begin
            timer_r <= timer_r + TIMER_W'(1);
          end
        end
        ST_REQ: begin
          if (save_ack) begin
            save_req_r <= 1'b0;
            pend_r     <= 1'b0;
            // A write that landed while the save was in flight is not in the
            // saved image, so start a fresh idle period instead of clearing.
            if (pend_r || sram_we_s) begin
              state_r <= ST_DIRTY;
              timer_r <= '0;
            end else begin
              state_r <= ST_IDLE;
              dirty_r <= 1'b0;
            end
          end else if (sram_we_s) begin
            pend_r <= 1'b1;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          timer_r    <= '0;
          pend_r     <= 1'b0;
          dirty_r    <= 1'b0;
          save_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign sram_dirty = dirty_r;
  assign save_req   = save_req_r;

`ifdef MAPPER_REG_READBACK_EN
  logic       d_oe_r;
  logic [7:0] d_to_cpu_r;

  assign rb_hit_s = access_s & rd & reg_area_s & (addr[11:0] == 12'h000);

  // Registered bank readback, refreshed every cycle while rd is held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_oe_r     <= 1'b0;
      d_to_cpu_r <= 8'h00;
    end else if (rb_hit_s) begin
      d_oe_r     <= 1'b1;
      d_to_cpu_r <= 8'(cur_bank_s);
    end else begin
      d_oe_r     <= 1'b0;
      d_to_cpu_r <= 8'h00;
    end
  end

  assign d_oe     = d_oe_r;
  assign d_to_cpu = d_to_cpu_r;
`else
  assign rb_hit_s = 1'b0;
  assign d_oe     = 1'b0;
  assign d_to_cpu = 8'h00;
`endif

endmodule

// File: tb/tb_cart_sram_mapper.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for cart_sram_mapper (SAVE_IDLE overridden to 8).
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_cart_sram_mapper;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] addr;
  logic [7:0]  d_from_cpu;
  logic        wr, rd, cs;
  logic [24:0] mem_addr;
  logic        mem_oe;
  logic [12:0] sram_addr;
  logic        sram_oe, sram_we;
  logic [7:0]  d_to_cpu;
  logic        d_oe;
  logic        sram_dirty, save_req, save_ack;

  int checks   = 0;
  int failures = 0;

  cart_sram_mapper #(.SAVE_IDLE(8)) dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .d_from_cpu(d_from_cpu),
    .wr(wr), .rd(rd), .cs(cs), .mem_addr(mem_addr), .mem_oe(mem_oe),
    .sram_addr(sram_addr), .sram_oe(sram_oe), .sram_we(sram_we),
    .d_to_cpu(d_to_cpu), .d_oe(d_oe), .sram_dirty(sram_dirty),
    .save_req(save_req), .save_ack(save_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic [7:0] d,
                       input logic c, input logic w, input logic r);
    addr = a; d_from_cpu = d; cs = c; wr = w; rd = r;
    #1;
  endtask

  task automatic bus_idle();
    cs = 1'b0; wr = 1'b0; rd = 1'b0; addr = 16'h0000; d_from_cpu = 8'h00;
  endtask

  task automatic reg_write(input logic [15:0] a, input logic [7:0] d);
    drive(a, d, 1'b1, 1'b1, 1'b0);
    tick();
    bus_idle();
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (!save_req && n < 30) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset();
    bus_idle();
    save_ack = 1'b0;
    reset_n  = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    bus_idle();
    save_ack = 1'b0;
    reset_n  = 1'b0;
    #3;
    checks++; if (save_req !== 1'b0) begin failures++; $display("FAIL reset_save_req got=%b exp=0", save_req); end
    checks++; if (sram_dirty !== 1'b0) begin failures++; $display("FAIL reset_dirty got=%b exp=0", sram_dirty); end
    checks++; if (d_oe !== 1'b0) begin failures++; $display("FAIL reset_d_oe got=%b exp=0", d_oe); end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_rom_map();
    logic [15:0] a_tab [4] = '{16'h4000, 16'h6000, 16'h8000, 16'hA000};
    logic [24:0] e_tab [4] = '{25'h00000, 25'h02000, 25'h04000, 25'h06000};
    for (int i = 0; i < 4; i++) begin
      drive(a_tab[i], 8'h00, 1'b1, 1'b0, 1'b0);
      checks++; if (mem_addr !== e_tab[i]) begin failures++; $display("FAIL rom_map_addr[%0d] got=%h exp=%h", i, mem_addr, e_tab[i]); end
      checks++; if (mem_oe !== 1'b1 || sram_oe !== 1'b0) begin failures++; $display("FAIL rom_map_oe[%0d] got mem_oe=%b sram_oe=%b exp 1/0", i, mem_oe, sram_oe); end
    end
    drive(16'hC000, 8'h00, 1'b1, 1'b0, 1'b1);
    checks++; if (mem_oe !== 1'b0 || sram_oe !== 1'b0 || mem_addr !== 25'h0) begin failures++; $display("FAIL out_of_range got mem_oe=%b sram_oe=%b mem_addr=%h exp 0/0/0", mem_oe, sram_oe, mem_addr); end
    bus_idle();
  endtask

  task automatic test_bank_write();
    drive(16'h7123, 8'h00, 1'b1, 1'b0, 1'b1);
    checks++; if (mem_addr !== 25'h03123) begin failures++; $display("FAIL bank_pre got=%h exp=03123", mem_addr); end
    // Mapping in the register-write cycle still uses the old bank 1.
    drive(16'h6000, 8'h05, 1'b1, 1'b1, 1'b0);
    checks++; if (mem_addr !== 25'h02000) begin failures++; $display("FAIL bank_write_cycle got=%h exp=02000", mem_addr); end
    tick();
    drive(16'h7123, 8'h00, 1'b1, 1'b0, 1'b1);
    checks++; if (mem_addr !== 25'h0B123) begin failures++; $display("FAIL bank_new got=%h exp=0B123", mem_addr); end
    bus_idle();
    reg_write(16'h4000, 8'h3F);
    drive(16'h4123, 8'h00, 1'b1, 1'b0, 1'b1);
    checks++; if (mem_addr !== 25'h00123 || mem_oe !== 1'b1) begin failures++; $display("FAIL fixed_win0 got=%h oe=%b exp=00123/1", mem_addr, mem_oe); end
    bus_idle();
  endtask

  task automatic test_sram_map();
    reg_write(16'hA000, 8'h30);
    drive(16'hB010, 8'h55, 1'b1, 1'b1, 1'b0);
    checks++; if (sram_we !== 1'b1 || sram_oe !== 1'b1 || mem_oe !== 1'b0) begin failures++; $display("FAIL sram_wr_en got we=%b oe=%b mem_oe=%b exp 1/1/0", sram_we, sram_oe, mem_oe); end
    checks++; if (sram_addr !== 13'h1010) begin failures++; $display("FAIL sram_addr got=%h exp=1010", sram_addr); end
    drive(16'hA010, 8'h55, 1'b1, 1'b1, 1'b0);
    checks++; if (sram_we !== 1'b0 || sram_oe !== 1'b1) begin failures++; $display("FAIL sram_reg_area got we=%b oe=%b exp 0/1", sram_we, sram_oe); end
    bus_idle();
    reg_write(16'h8000, 8'h10);
    drive(16'h9010, 8'h55, 1'b1, 1'b1, 1'b0);
    checks++; if (sram_we !== 1'b0 || sram_oe !== 1'b1) begin failures++; $display("FAIL sram_masked got we=%b oe=%b exp 0/1", sram_we, sram_oe); end
    bus_idle();
  endtask

  task automatic test_save_basic();
    int n;
    do_reset();
    reg_write(16'hA000, 8'h30);
    reg_write(16'hB000, 8'hAA);  // SRAM write in window 3
    checks++; if (sram_dirty !== 1'b1 || save_req !== 1'b0) begin failures++; $display("FAIL save_dirty got dirty=%b req=%b exp 1/0", sram_dirty, save_req); end
    wait_req(n);
    checks++; if (n != 8) begin failures++; $display("FAIL save_req_delay got=%0d exp=8", n); end
    save_ack = 1'b1;
    tick();
    save_ack = 1'b0;
    checks++; if (save_req !== 1'b0 || sram_dirty !== 1'b0) begin failures++; $display("FAIL save_ack_clear got req=%b dirty=%b exp 0/0", save_req, sram_dirty); end
  endtask

  task automatic test_save_pending();
    int  n;
    logic seen = 1'b0;
    reg_write(16'hB001, 8'h01);
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) begin
        tick();
        seen = seen | save_req;
      end
      reg_write(16'hB002, 8'h02);
      seen = seen | save_req;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL save_busy_writes got req_seen=%b exp 0", seen); end
    wait_req(n);
    checks++; if (n != 8) begin failures++; $display("FAIL save_after_busy got=%0d exp=8", n); end
    reg_write(16'hB003, 8'h03);  // write while the request is outstanding
    checks++; if (save_req !== 1'b1) begin failures++; $display("FAIL req_hold got=%b exp=1", save_req); end
    save_ack = 1'b1;
    tick();
    save_ack = 1'b0;
    checks++; if (save_req !== 1'b0 || sram_dirty !== 1'b1) begin failures++; $display("FAIL pend_ack got req=%b dirty=%b exp 0/1", save_req, sram_dirty); end
    wait_req(n);
    checks++; if (n != 8) begin failures++; $display("FAIL rereq_delay got=%0d exp=8", n); end
    // Write and acknowledge in the same cycle.
    save_ack = 1'b1;
    reg_write(16'hB004, 8'h04);
    save_ack = 1'b0;
    checks++; if (save_req !== 1'b0 || sram_dirty !== 1'b1) begin failures++; $display("FAIL same_cycle_ack got req=%b dirty=%b exp 0/1", save_req, sram_dirty); end
    wait_req(n);
    checks++; if (n != 8) begin failures++; $display("FAIL same_cycle_rereq got=%0d exp=8", n); end
    // Asynchronous reset in the middle of the request.
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (save_req !== 1'b0 || sram_dirty !== 1'b0) begin failures++; $display("FAIL async_reset got req=%b dirty=%b exp 0/0", save_req, sram_dirty); end
    drive(16'hA000, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++; if (mem_oe !== 1'b1 || mem_addr !== 25'h06000) begin failures++; $display("FAIL async_reset_bank got oe=%b addr=%h exp 1/06000", mem_oe, mem_addr); end
    bus_idle();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_readback();
    reg_write(16'h6000, 8'h05);
    drive(16'h6000, 8'h00, 1'b1, 1'b0, 1'b1);
`ifdef MAPPER_REG_READBACK_EN
    checks++; if (mem_oe !== 1'b0 || sram_oe !== 1'b0) begin failures++; $display("FAIL rb_suppress got mem_oe=%b sram_oe=%b exp 0/0", mem_oe, sram_oe); end
    tick();
    checks++; if (d_oe !== 1'b1 || d_to_cpu !== 8'h05) begin failures++; $display("FAIL rb_data got d_oe=%b d=%h exp 1/05", d_oe, d_to_cpu); end
    tick();
    checks++; if (d_oe !== 1'b1 || d_to_cpu !== 8'h05) begin failures++; $display("FAIL rb_hold got d_oe=%b d=%h exp 1/05", d_oe, d_to_cpu); end
    bus_idle();
    tick();
    checks++; if (d_oe !== 1'b0) begin failures++; $display("FAIL rb_release got d_oe=%b exp 0", d_oe); end
`else
    checks++; if (mem_oe !== 1'b1 || mem_addr !== 25'h0A000) begin failures++; $display("FAIL rb_off_map got oe=%b addr=%h exp 1/0A000", mem_oe, mem_addr); end
    tick();
    checks++; if (d_oe !== 1'b0 || d_to_cpu !== 8'h00) begin failures++; $display("FAIL rb_off_data got d_oe=%b d=%h exp 0/00", d_oe, d_to_cpu); end
    bus_idle();
`endif
  endtask

  initial begin
    bus_idle();
    save_ack = 1'b0;
    reset_n  = 1'b0;
    test_reset();
    test_rom_map();
    test_bank_write();
    test_sram_map();
    test_save_basic();
    test_save_pending();
    test_readback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
